// File: rtl/btn_event_ctrl_pkg.sv
// btn_pkg: shared state type and default 100 MHz timing constants for button front-ends
package btn_pkg;
   typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
   localparam int DEBOUNCE_CYC_DEF = 1_000_000;
   localparam int LONG_CYC_DEF     = 100_000_000;
   localparam int REPEAT_CYC_DEF   = 20_000_000;
endpackage

// File: rtl/btn_event_ctrl_if.sv
// btn_event_ctrl_if: raw pin in, debounced level and event strobes out
interface btn_event_ctrl_if;
   logic btn;
   logic btn_level;
   logic btn_pe;
   logic btn_ne;
   logic btn_short;
   logic btn_long;
   logic btn_rep;
   modport master (output btn, input btn_level, btn_pe, btn_ne, btn_short, btn_long, btn_rep);
   modport slave  (input btn, output btn_level, btn_pe, btn_ne, btn_short, btn_long, btn_rep);
endinterface

// File: rtl/btn_event_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchroniser with a selectable reset level
module sync_2ff #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic s1;
   // shift the asynchronous input through two flops
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) {q, s1} <= {RST_VAL, RST_VAL};
      else {q, s1} <= {s1, d};
endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounces a push-button and emits press/release/short/long/repeat strobes
module btn_event_ctrl
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
   parameter int LONG_CYC       = LONG_CYC_DEF,
   parameter int REPEAT_CYC     = REPEAT_CYC_DEF,
   parameter bit BTN_ACTIVE_LOW = 1'b0
) (
   input logic clk,
   input logic reset_n,
   btn_event_ctrl_if.slave io
);
   localparam int HOLD_MAX = LONG_CYC > REPEAT_CYC ? LONG_CYC : REPEAT_CYC;
   localparam int DW = $clog2(DEBOUNCE_CYC);
   localparam int HW = $clog2(HOLD_MAX);
   localparam logic [DW-1:0] DEB_TOP  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] LONG_TOP = HW'(LONG_CYC - 1);
   localparam logic [HW-1:0] REP_TOP  = HW'(REPEAT_CYC - 1);
   logic raw_s, flip, long_hit, rep_hit;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   state_t state;
   sync_2ff #(.RST_VAL(1'b0)) u_sync (
      .clk(clk),
      .reset_n(reset_n),
      .d(io.btn ^ BTN_ACTIVE_LOW),
      .q(raw_s)
   );
   assign flip     = (raw_s != io.btn_level) && (deb_cnt == DEB_TOP);
   assign long_hit = (state == PRESSED) && (hold_cnt == LONG_TOP);
   assign rep_hit  = (REPEAT_CYC != 0) && (state == LONG) && (hold_cnt == REP_TOP);
   // debounce filter, hold timer and event FSM; a release always beats a long/repeat on the same edge
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= IDLE;
         deb_cnt      <= '0;
         hold_cnt     <= '0;
         io.btn_level <= 1'b0;
         io.btn_pe    <= 1'b0;
         io.btn_ne    <= 1'b0;
         io.btn_short <= 1'b0;
         io.btn_long  <= 1'b0;
         io.btn_rep   <= 1'b0;
      end else begin
         deb_cnt      <= (raw_s == io.btn_level || flip) ? '0 : deb_cnt + 1'b1;
         io.btn_level <= flip ? raw_s : io.btn_level;
         io.btn_pe    <= flip && raw_s;
         io.btn_ne    <= flip && !raw_s;
         io.btn_short <= flip && !raw_s && state == PRESSED;
         io.btn_long  <= long_hit && !flip;
         io.btn_rep   <= rep_hit && !flip;
         hold_cnt     <= (flip || long_hit || rep_hit || state == IDLE || (state == LONG && REPEAT_CYC == 0))
                         ? '0 : hold_cnt + 1'b1;
         state        <= flip ? (raw_s ? PRESSED : IDLE) : long_hit ? LONG : state;
      end
endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Button front-end stage that sits directly upstream of the LED brightness / fan speed stepper.
- Turns a raw, bouncy, asynchronous push-button into clean, single-cycle event pulses: press, release, short-click, long-press and auto-repeat.
- Downstream stages consume the btn_pe / btn_short / btn_long strobes to step their state machines.

Parameters:
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal values are 2 and above.
- LONG_CYC, 100_000_000, cycles from the accepted press to the btn_long strobe; legal values are 2 and above.
- REPEAT_CYC, 20_000_000, period of btn_rep strobes after btn_long; 0 disables repeat; otherwise 2 and above.
- BTN_ACTIVE_LOW, 0, 1 means the pin reads 0 when pressed; the pin is inverted before synchronisation.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn  in  1  raw button pin, asynchronous to clk.
- btn_level  out  1  debounced pressed level (1 = pressed).
- btn_pe  out  1  one-cycle strobe on an accepted press.
- btn_ne  out  1  one-cycle strobe on an accepted release.
- btn_short  out  1  one-cycle strobe on a release that happens before btn_long has fired.
- btn_long  out  1  one-cycle strobe once per press, after the button has been held LONG_CYC cycles.
- btn_rep  out  1  one-cycle strobe every REPEAT_CYC cycles after btn_long while the button stays held.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- While reset_n = 0:
  - all outputs are 0;
  - all counters are 0;
  - the synchroniser flops hold the not-pressed level.
- Synchroniser: after optional inversion, the pin passes through 2 flops to give raw_s. raw_s is the only signal the filter sees.
- Debounce filter:
  - deb_cnt has width $clog2(DEBOUNCE_CYC).
  - Each edge with raw_s == btn_level: deb_cnt <= 0.
  - Each edge with raw_s != btn_level and deb_cnt < DEBOUNCE_CYC-1: deb_cnt increments.
  - Each edge with raw_s != btn_level and deb_cnt == DEBOUNCE_CYC-1: btn_level <= raw_s, deb_cnt <= 0, and btn_pe or btn_ne is set for that single cycle.
- Latency: btn_pe / btn_ne go high after edge DEBOUNCE_CYC+2, counting the first edge that samples the new pin level as edge 1. All outputs are registered.
- Glitch rejection: any excursion of raw_s shorter than DEBOUNCE_CYC cycles produces no event and leaves btn_level unchanged.
- Hold timer:
  - hold_cnt has width $clog2(max(LONG_CYC, REPEAT_CYC)).
  - It is cleared on the press-accept edge and increments each edge while btn_level = 1.
- State machine, states IDLE, PRESSED, LONG:
  - IDLE -> PRESSED on the press-accept edge.
  - PRESSED -> LONG on the edge where hold_cnt == LONG_CYC-1. That edge pulses btn_long and clears hold_cnt.
  - In LONG with REPEAT_CYC != 0: btn_rep pulses on each edge where hold_cnt == REPEAT_CYC-1, and hold_cnt clears on that edge. The first btn_rep comes REPEAT_CYC edges after btn_long.
  - PRESSED -> IDLE on the release-accept edge. btn_ne and btn_short pulse on the same cycle.
  - LONG -> IDLE on the release-accept edge. btn_ne pulses; btn_short stays 0.
- Simultaneous events: if the release-accept edge coincides with hold_cnt == LONG_CYC-1 or REPEAT_CYC-1, release wins. Only btn_ne pulses, plus btn_short when the state was PRESSED. No btn_long or btn_rep is issued on that edge.
- Mutual exclusion: no two of btn_pe, btn_long, btn_rep are ever high in the same cycle.
- Counter saturation: counters never wrap. deb_cnt is bounded by DEBOUNCE_CYC-1. hold_cnt is cleared at each terminal value.
- Reset mid-operation: all strobes are dropped and the state machine returns to IDLE. If the button is still held after reset_n rises, it is treated as a new press and produces btn_pe after DEBOUNCE_CYC+2 edges.
- btn_level mirrors the state machine: it is 1 in PRESSED and LONG.

Decomposition:
- Package btn_pkg holds:
  - the state enum typedef (IDLE, PRESSED, LONG);
  - the default cycle constants for 100 MHz: 10 ms, 1 s, 200 ms.
- Sub-module sync_2ff: 2-flop synchroniser with a parameterised reset value. The same sub-module is reused for the fan and timer buttons.

Test Plan (params DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5):
- Clean press held 10 cycles, then released -> btn_pe after edge 6 from the first sample; btn_ne plus btn_short 6 edges after the release sample; btn_long never fires.
- Bounce: pin toggles 1,0,1,0 with 1-3 cycle pulses, then stays 1 -> exactly one btn_pe, 6 edges after the last transition to 1; no btn_ne.
- Hold 40 cycles after btn_pe -> btn_long 20 edges after btn_pe; btn_rep at +5 and +10 from btn_long, with none in the same cycle as btn_long; release gives btn_ne with no btn_short.
- Release timed so the release-accept edge equals hold_cnt == 19 -> btn_ne and btn_short high; btn_long stays 0 for the whole press.
- reset_n pulsed low for 1 cycle while in LONG with the pin still held -> all outputs 0 immediately; btn_pe again 6 edges after reset_n rises; btn_long 20 edges after that.
- BTN_ACTIVE_LOW=1 with the pin idle at 1 out of reset -> no events; pin to 0 -> btn_pe after 6 edges.
